// File: rtl/regex_stream_scheduler_pkg.sv
// Shared types and constants for the regex stream scheduler.
package regex_sched_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      FILL,
      ISSUE_LAST,
      WAIT,
      EMIT,
      CLEAR
   } state_t;

   localparam logic [BYTE_W-1:0] RES_NO_MATCH = 8'h00;
   localparam logic [BYTE_W-1:0] RES_MATCH    = 8'h01;
   localparam logic [BYTE_W-1:0] RES_TIMEOUT  = 8'hFF;

endpackage

// File: rtl/regex_stream_scheduler_if.sv
// Host byte stream, matcher step/verdict and result stream of the scheduler.
// slave is the scheduler's view; master is the surrounding host/matcher/consumer.
interface regex_stream_scheduler_if
   import regex_sched_pkg::*;
#(
   parameter int REPLICATION_FACTOR = 3
);
   logic [BYTE_W-1:0]                    in_data;
   logic                                 in_valid;
   logic                                 in_ready;
   logic                                 in_last;
   logic [BYTE_W*REPLICATION_FACTOR-1:0] m_data;
   logic                                 m_last;
   logic                                 m_enable;
   logic                                 m_clear;
   logic                                 m_result;
   logic                                 m_result_valid;
   logic [BYTE_W-1:0]                    out_data;
   logic                                 out_valid;
   logic                                 out_ready;
   logic                                 out_last;
   logic                                 busy;

   modport slave (
      input  in_data, in_valid, in_last, m_result, m_result_valid, out_ready,
      output in_ready, m_data, m_last, m_enable, m_clear, out_data, out_valid, out_last, busy
   );

   modport master (
      output in_data, in_valid, in_last, m_result, m_result_valid, out_ready,
      input  in_ready, m_data, m_last, m_enable, m_clear, out_data, out_valid, out_last, busy
   );
endinterface

// File: rtl/regex_stream_scheduler_stream_word_packer.sv
// Packs accepted bytes into matcher words (lane 0 first), pads a short final
// word and holds the completed word in an issue register for one step pulse.
module stream_word_packer
   import regex_sched_pkg::*;
#(
   parameter int               REPLICATION_FACTOR = 3,
   parameter logic [BYTE_W-1:0] PAD_BYTE          = 8'h00
)(
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 accept,
   input  logic [BYTE_W-1:0]                    data,
   input  logic                                 last,
   output logic [BYTE_W*REPLICATION_FACTOR-1:0] word,
   output logic                                 word_last,
   output logic                                 word_done,
   output logic                                 empty
);
   localparam int R  = REPLICATION_FACTOR;
   localparam int CW = (R > 1) ? $clog2(R) : 1;

   logic [R-1:0][BYTE_W-1:0] acc;
   logic [R-1:0][BYTE_W-1:0] merged;
   logic [CW-1:0]            count;
   logic                     complete;

   // Incoming byte lands in lane[count]; lanes above it read as padding, so a
   // short final word is already in issue form.
   always_comb begin
      merged = acc;
      for (int i = 0; i < R; i++) begin
         if (i == int'(count))     merged[i] = data;
         else if (i > int'(count)) merged[i] = PAD_BYTE;
      end
   end

   assign complete = accept && (last || (count == CW'(R - 1)));
   assign empty    = (count == '0);

   // Lane accumulation; completed word moves to the issue register and the
   // step strobe fires the following cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count     <= '0;
         word      <= '0;
         word_last <= 1'b0;
         word_done <= 1'b0;
      end else begin
         word_done <= complete;
         if (accept) begin
            acc[count] <= data;
            if (complete) begin
               count     <= '0;
               word      <= merged;
               word_last <= last;
            end else begin
               count <= count + CW'(1);
            end
         end
      end
   end
endmodule

// File: rtl/regex_stream_scheduler.sv
// Frame sequencer: feeds packed words to the matcher, waits for its verdict
// (or times out), returns a one-byte result frame and clears the matcher.
module regex_stream_scheduler
   import regex_sched_pkg::*;
#(
   parameter int                REPLICATION_FACTOR = 3,
   parameter logic [BYTE_W-1:0] PAD_BYTE           = 8'h00,
   parameter int                RESULT_TIMEOUT     = 64,
   parameter int                TIMEOUT_WIDTH      = 8
)(
   input logic                      clock,
   input logic                      reset,
   regex_stream_scheduler_if.slave  bus
);
   state_t                                 state, state_nxt;
   logic [TIMEOUT_WIDTH-1:0]               tmo_cnt;
   logic [BYTE_W-1:0]                      result;
   logic                                   rst_q;
   logic                                   accept;
   logic                                   timed_out;
   logic                                   pk_done, pk_last, pk_empty;
   logic [BYTE_W*REPLICATION_FACTOR-1:0]   pk_word;

   assign accept    = bus.in_valid && bus.in_ready;
   // Counter is 0 in the final step cycle, so EMIT follows RESULT_TIMEOUT
   // cycles after that step when the matcher stays silent.
   assign timed_out = (tmo_cnt >= TIMEOUT_WIDTH'(RESULT_TIMEOUT - 1));

   stream_word_packer #(
      .REPLICATION_FACTOR (REPLICATION_FACTOR),
      .PAD_BYTE           (PAD_BYTE)
   ) u_packer (
      .clock     (clock),
      .reset     (reset),
      .accept    (accept),
      .data      (bus.in_data),
      .last      (bus.in_last),
      .word      (pk_word),
      .word_last (pk_last),
      .word_done (pk_done),
      .empty     (pk_empty)
   );

   // Next state and state-decoded handshake/clear outputs.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.m_clear   = !reset || rst_q;
      case (state)
         FILL: begin
            bus.in_ready = 1'b1;
            if (accept && bus.in_last) state_nxt = ISSUE_LAST;
         end
         ISSUE_LAST: state_nxt = WAIT;
         WAIT:       if (bus.m_result_valid || timed_out) state_nxt = EMIT;
         EMIT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = CLEAR;
         end
         CLEAR: begin
            bus.m_clear = 1'b1;
            state_nxt   = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // State register, verdict timer, result capture and post-reset clear stretch.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= FILL;
         tmo_cnt <= '0;
         result  <= RES_NO_MATCH;
         rst_q   <= 1'b1;
      end else begin
         state <= state_nxt;
         rst_q <= 1'b0;
         if (state == ISSUE_LAST || state == WAIT) tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
         else                                      tmo_cnt <= '0;
         if (state == WAIT) begin
            if (bus.m_result_valid) result <= {7'b0, bus.m_result};
            else if (timed_out)     result <= RES_TIMEOUT;
         end
      end
   end

   assign bus.m_data   = pk_word;
   assign bus.m_last   = pk_last;
   assign bus.m_enable = pk_done;
   assign bus.out_data = result;
   assign bus.out_last = 1'b1;
   assign bus.busy     = !((state == FILL) && pk_empty);
endmodule

// File: doc/regex_stream_scheduler.md
Name: regex_stream_scheduler

Overview:
- Sequences a byte stream from the host link into the replicated regex matcher (8*REPLICATION_FACTOR-bit words, one step per enable).
- Packs bytes into words and pads the final partial word.
- Steps the matcher exactly once per word and waits for its boolean verdict, with a timeout.
- Returns a one-byte result frame on a valid/ready interface with real backpressure. Clears the matcher between frames.

Parameters:
- REPLICATION_FACTOR, 3: bytes per matcher word.
- PAD_BYTE, 8'h00: fill value for unused lanes of the final word.
- RESULT_TIMEOUT, 64: cycles to wait for a verdict after the last word is issued (>=1).
- TIMEOUT_WIDTH, 8: width of the timeout counter; must hold RESULT_TIMEOUT.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  byte present.
- in_ready  out  1  scheduler accepts byte.
- in_last  in  1  byte is last of frame.
- m_data  out  8*REPLICATION_FACTOR  word to matcher; first byte of word in lane [7:0], ascending.
- m_last  out  1  word is final word of frame.
- m_enable  out  1  one-cycle step strobe to matcher.
- m_clear  out  1  active-high matcher reset.
- m_result  in  1  matcher verdict.
- m_result_valid  in  1  verdict strobe.
- out_data  out  8  result code.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_last  out  1  constant 1; every result is a one-byte frame.
- busy  out  1  high in any state other than FILL with lane count 0.

Behaviour:
- Reset (reset==0, sampled on the clock edge):
  - State goes to FILL; lane count 0; partial word discarded.
  - m_enable=0, out_valid=0, out_data=8'h00, m_data=0, m_last=0.
  - m_clear=1 for the whole reset and for one cycle after reset deasserts.
  - A reset mid-frame drops all accumulated bytes; no result is emitted for that frame.
- Handshake: a byte transfers when in_valid&&in_ready; a result transfers when out_valid&&out_ready. out_valid and out_data stay stable until accepted.
- States:
  - FILL
    - in_ready=1.
    - An accepted byte is written to lane[count] of the accumulator.
    - When the word completes (count==REPLICATION_FACTOR-1, or in_last on the accepted byte):
      - Copy the accumulator to the issue register; unfilled lanes become PAD_BYTE.
      - Set m_last=in_last and reset count to 0.
      - Next cycle: m_enable=1 for exactly one cycle, with m_data and m_last driven from the issue register.
    - Non-last words: stay in FILL. Acceptance continues during issue, so a sustained 1 byte/cycle is possible.
    - Last word: go to ISSUE_LAST.
  - ISSUE_LAST: in_ready=0; m_enable=1, m_last=1; go to WAIT; timeout counter reset to 0.
  - WAIT
    - in_ready=0; the counter increments each cycle.
    - If m_result_valid: capture out_data={7'b0,m_result} (8'h00 no match, 8'h01 match); go to EMIT.
    - Else if counter==RESULT_TIMEOUT-1: out_data=8'hFF; go to EMIT.
    - m_result_valid wins on the same cycle as the timeout.
  - EMIT: in_ready=0; out_valid=1; on out_ready go to CLEAR.
  - CLEAR: m_clear=1 for one cycle; in_ready=0; go to FILL.
- m_result_valid outside WAIT is ignored; no state change.
- Latency:
  - Last byte accepted in cycle t gives m_enable/m_last at t+1.
  - Verdict at t+1+L gives out_valid at t+2+L.
  - Earliest acceptance of the next frame's first byte is 2 cycles after out_valid&&out_ready.
- A single-byte frame is one word: lane 0 = byte, other lanes PAD_BYTE.
- in_valid gaps mid-word hold the lane count; no padding is inserted until in_last.

Decomposition:
- Shared package regex_sched_pkg:
  - State encoding (FILL, ISSUE_LAST, WAIT, EMIT, CLEAR).
  - Result codes RES_NO_MATCH=8'h00, RES_MATCH=8'h01, RES_TIMEOUT=8'hFF.
- One sub-module, stream_word_packer:
  - Holds the byte-to-word accumulator, lane counter, padding and issue register.
  - Outputs a word_done pulse.
- The top level holds the FSM, timeout counter, result register and clear sequencing.

Test Plan:
- R=3, frame 61 40 62 (last on 62); matcher returns 1 two cycles after the step. Expect a single m_enable with m_data=24'h624061 and m_last=1, then out_data=8'h01 with out_last=1, then a one-cycle m_clear.
- 4-byte frame 61 62 63 64. Expect two steps: 24'h636261 with m_last=0, then 24'h000064 with m_last=1. A verdict of 0 gives out_data=8'h00.
- out_ready held low for 10 cycles after out_valid. Expect out_valid/out_data stable, in_ready=0 and no m_enable throughout; one transfer when out_ready rises.
- RESULT_TIMEOUT=16, matcher silent. Expect out_data=8'hFF exactly 16 cycles after the last step; a late m_result_valid after EMIT has no effect.
- reset low for one cycle after 2 bytes of a frame. Expect no m_enable, no out_valid, m_clear high through the following cycle. A new 3-byte frame then packs from lane 0.
- Back-to-back 1-byte frames with random in_valid gaps. Expect one result per frame in order, each m_data=24'h0000xx.
